// File: rtl/exe_stage.sv
// Execute stage of the LA32R 5-stage pipeline: holds the decoded instruction,
// computes the ALU result, issues one data-SRAM request per memory instruction
// and forwards its write-back information to decode.
module exe_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int unsigned ALU_OP_W = 12
) (
    input  logic                clk,
    input  logic                reset,
    // decode -> execute handshake and payload
    input  logic                ds_to_es_valid,
    output logic                es_allow_in,
    input  logic [31:0]         ds_pc,
    input  logic [31:0]         ds_alu_src1,
    input  logic [31:0]         ds_alu_src2,
    input  logic [ALU_OP_W-1:0] ds_alu_op,
    input  logic                ds_mem_re,
    input  logic [3:0]          ds_mem_we,
    input  logic [31:0]         ds_st_data,
    input  logic [3:0]          ds_rf_we,
    input  logic [4:0]          ds_rf_waddr,
    // execute -> memory handshake and payload
    input  logic                ms_allow_in,
    output logic                es_to_ms_valid,
    output logic [31:0]         es_pc,
    output logic [31:0]         es_alu_result,
    output logic                es_mem_re_o,
    // forwarding back to decode
    output logic [3:0]          es_rf_we,
    output logic [4:0]          es_rf_waddr,
    output logic [31:0]         es_rf_wdata,
    output logic                es_is_load,
    // data SRAM request channel
    output logic                data_sram_req,
    output logic                data_sram_wr,
    output logic [3:0]          data_sram_wstrb,
    output logic [31:0]         data_sram_addr,
    output logic [31:0]         data_sram_wdata,
    input  logic                data_sram_addr_ok
);

    typedef enum logic [0:0] {StIdle, StDone} mem_state_e;

    logic                es_valid_q;
    logic [31:0]         es_pc_q;
    logic [31:0]         src1_q;
    logic [31:0]         src2_q;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic                mem_re_q;
    logic [3:0]          mem_we_q;
    logic [31:0]         st_data_q;
    logic [3:0]          rf_we_q;
    logic [4:0]          rf_waddr_q;
    mem_state_e          state_q, state_d;

    logic        mem_op;
    logic        req_done;
    logic        es_ready_go;
    logic        es_leave;
    logic [31:0] alu_result;
    logic [4:0]  shamt;

    assign mem_op      = es_valid_q & (mem_re_q | (|mem_we_q));
    // req_done is exactly "request already accepted for the held instruction"
    assign req_done    = (state_q == StDone);
    assign es_ready_go = ~mem_op | req_done | (data_sram_req & data_sram_addr_ok);
    assign es_leave    = es_valid_q & es_ready_go & ms_allow_in;
    assign es_allow_in = ~es_valid_q | (es_ready_go & ms_allow_in);

    // Pipeline register: valid follows decode on accept, payload only on real instructions
    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            es_pc_q    <= RESET_PC;
            src1_q     <= '0;
            src2_q     <= '0;
            alu_op_q   <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= '0;
            st_data_q  <= '0;
            rf_we_q    <= '0;
            rf_waddr_q <= '0;
        end else if (es_allow_in) begin
            es_valid_q <= ds_to_es_valid;
            if (ds_to_es_valid) begin
                es_pc_q    <= ds_pc;
                src1_q     <= ds_alu_src1;
                src2_q     <= ds_alu_src2;
                alu_op_q   <= ds_alu_op;
                mem_re_q   <= ds_mem_re;
                mem_we_q   <= ds_mem_we;
                st_data_q  <= ds_st_data;
                rf_we_q    <= ds_rf_we;
                rf_waddr_q <= ds_rf_waddr;
            end
        end
    end

    // ALU: OR of every per-op result gated by its one-hot select bit
    always_comb begin
        shamt      = src2_q[4:0];
        alu_result = '0;
        alu_result = alu_result | ({32{alu_op_q[0]}}  & (src1_q + src2_q));
        alu_result = alu_result | ({32{alu_op_q[1]}}  & (src1_q - src2_q));
        alu_result = alu_result | ({32{alu_op_q[2]}}
                                   & {31'b0, $signed(src1_q) < $signed(src2_q)});
        alu_result = alu_result | ({32{alu_op_q[3]}}  & {31'b0, src1_q < src2_q});
        alu_result = alu_result | ({32{alu_op_q[4]}}  & (src1_q & src2_q));
        alu_result = alu_result | ({32{alu_op_q[5]}}  & ~(src1_q | src2_q));
        alu_result = alu_result | ({32{alu_op_q[6]}}  & (src1_q | src2_q));
        alu_result = alu_result | ({32{alu_op_q[7]}}  & (src1_q ^ src2_q));
        alu_result = alu_result | ({32{alu_op_q[8]}}  & (src1_q << shamt));
        alu_result = alu_result | ({32{alu_op_q[9]}}  & (src1_q >> shamt));
        alu_result = alu_result | ({32{alu_op_q[10]}} & 32'($signed(src1_q) >>> shamt));
        alu_result = alu_result | ({32{alu_op_q[11]}} & src2_q);
    end

    // Memory FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory FSM next state: park in StDone only when the accepted request cannot leave yet
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (data_sram_req && data_sram_addr_ok && !es_leave) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (es_leave) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign data_sram_req   = mem_op & ~req_done;
    assign data_sram_wr    = |mem_we_q;
    assign data_sram_wstrb = mem_we_q;
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = st_data_q;

    assign es_to_ms_valid  = es_valid_q & es_ready_go;
    assign es_pc           = es_pc_q;
    assign es_alu_result   = alu_result;
    assign es_mem_re_o     = mem_re_q;

    assign es_rf_we        = es_valid_q ? rf_we_q : 4'b0;
    assign es_rf_waddr     = rf_waddr_q;
    assign es_rf_wdata     = alu_result;
    // ALU result of a load is only the address, so decode must stall on a match
    assign es_is_load      = es_valid_q & mem_re_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, flow, backpressure, memory handshake, reset.
module tb_exe_stage;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLT  = 12'h004;
    localparam logic [11:0] OP_SLTU = 12'h008;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_to_es_valid;
    logic        es_allow_in;
    logic [31:0] ds_pc, ds_alu_src1, ds_alu_src2, ds_st_data;
    logic [11:0] ds_alu_op;
    logic        ds_mem_re;
    logic [3:0]  ds_mem_we, ds_rf_we;
    logic [4:0]  ds_rf_waddr;
    logic        ms_allow_in;
    logic        es_to_ms_valid;
    logic [31:0] es_pc, es_alu_result;
    logic        es_mem_re_o;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_rf_wdata;
    logic        es_is_load;
    logic        data_sram_req, data_sram_wr;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr, data_sram_wdata;
    logic        data_sram_addr_ok;

    int unsigned passed = 0;
    int unsigned total  = 0;

    exe_stage #(
        .RESET_PC (32'h1c000000),
        .ALU_OP_W (12)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_to_es_valid    (ds_to_es_valid),
        .es_allow_in       (es_allow_in),
        .ds_pc             (ds_pc),
        .ds_alu_src1       (ds_alu_src1),
        .ds_alu_src2       (ds_alu_src2),
        .ds_alu_op         (ds_alu_op),
        .ds_mem_re         (ds_mem_re),
        .ds_mem_we         (ds_mem_we),
        .ds_st_data        (ds_st_data),
        .ds_rf_we          (ds_rf_we),
        .ds_rf_waddr       (ds_rf_waddr),
        .ms_allow_in       (ms_allow_in),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_pc             (es_pc),
        .es_alu_result     (es_alu_result),
        .es_mem_re_o       (es_mem_re_o),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_rf_wdata       (es_rf_wdata),
        .es_is_load        (es_is_load),
        .data_sram_req     (data_sram_req),
        .data_sram_wr      (data_sram_wr),
        .data_sram_wstrb   (data_sram_wstrb),
        .data_sram_addr    (data_sram_addr),
        .data_sram_wdata   (data_sram_wdata),
        .data_sram_addr_ok (data_sram_addr_ok)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Advance one clock; inputs change 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] pc, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [11:0] op, input logic re, input logic [3:0] we,
                       input logic [31:0] st, input logic [3:0] rfwe, input logic [4:0] wa);
        ds_to_es_valid = 1'b1;
        ds_pc          = pc;
        ds_alu_src1    = s1;
        ds_alu_src2    = s2;
        ds_alu_op      = op;
        ds_mem_re      = re;
        ds_mem_we      = we;
        ds_st_data     = st;
        ds_rf_we       = rfwe;
        ds_rf_waddr    = wa;
    endtask

    // Load one instruction into an empty/draining stage, then present a bubble
    task automatic issue(input logic [31:0] s1, input logic [31:0] s2, input logic [11:0] op);
        put(32'h1c000010, s1, s2, op, 1'b0, 4'h0, 32'h0, 4'hf, 5'd3);
        tick();
        ds_to_es_valid = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        put(32'h0, 32'h0, 32'h0, 12'h0, 1'b0, 4'h0, 32'h0, 4'h0, 5'd0);
        ds_to_es_valid    = 1'b0;
        ms_allow_in       = 1'b1;
        data_sram_addr_ok = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        check("rst_req", 32'(data_sram_req), 32'd0);
        check("rst_rf_we", 32'(es_rf_we), 32'd0);
        check("rst_is_load", 32'(es_is_load), 32'd0);
        check("rst_pc", es_pc, 32'h1c000000);
        check("rst_allow_in", 32'(es_allow_in), 32'd1);
        check("rst_alu_zero_op", es_alu_result, 32'h0);

        // ALU vectors
        issue(32'h7fffffff, 32'h1, OP_ADD);
        check("add_wrap", es_alu_result, 32'h80000000);
        check("add_rf_wdata", es_rf_wdata, 32'h80000000);
        check("add_rf_we", 32'(es_rf_we), 32'hf);
        check("add_rf_waddr", 32'(es_rf_waddr), 32'd3);
        check("add_to_ms_valid", 32'(es_to_ms_valid), 32'd1);
        check("add_pc", es_pc, 32'h1c000010);
        issue(32'h0, 32'h1, OP_SUB);
        check("sub_wrap", es_alu_result, 32'hffffffff);
        issue(32'hffffffff, 32'h1, OP_SLT);
        check("slt_signed", es_alu_result, 32'h1);
        issue(32'hffffffff, 32'h1, OP_SLTU);
        check("sltu_unsigned", es_alu_result, 32'h0);
        issue(32'h80000000, 32'h21, OP_SRA);
        check("sra_arith", es_alu_result, 32'hc0000000);
        issue(32'h0, 32'h12345000, OP_LUI);
        check("lui", es_alu_result, 32'h12345000);
        issue(32'ha5a5a5a5, 32'hffff0000, OP_XOR);
        check("xor", es_alu_result, 32'h5a5aa5a5);
        issue(32'h5, 32'h6, 12'h000);
        check("op_none", es_alu_result, 32'h0);

        // Back-to-back adds: one result per cycle, stage never stalls
        for (int i = 0; i < 3; i++) begin
            put(32'h1c000020 + 32'(4 * i), 32'h10 * 32'(i + 1), 32'h1, OP_ADD,
                1'b0, 4'h0, 32'h0, 4'hf, 5'd4);
            tick();
            check("flow_valid", 32'(es_to_ms_valid), 32'd1);
            check("flow_allow_in", 32'(es_allow_in), 32'd1);
            check("flow_result", es_alu_result, 32'h10 * 32'(i + 1) + 32'h1);
        end
        ds_to_es_valid = 1'b0;
        tick();
        check("bubble_valid", 32'(es_to_ms_valid), 32'd0);
        check("bubble_rf_we", 32'(es_rf_we), 32'd0);
        check("bubble_payload_kept", es_alu_result, 32'h31);

        // Backpressure from MEM holds payload and valid
        put(32'h1c000040, 32'h100, 32'h200, OP_ADD, 1'b0, 4'h0, 32'h0, 4'hf, 5'd5);
        tick();
        ms_allow_in = 1'b0;
        put(32'h1c000044, 32'hdead, 32'h0, OP_ADD, 1'b0, 4'h0, 32'h0, 4'hf, 5'd6);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("bp_allow_in", 32'(es_allow_in), 32'd0);
            check("bp_valid", 32'(es_to_ms_valid), 32'd1);
            check("bp_result", es_alu_result, 32'h300);
            check("bp_pc", es_pc, 32'h1c000040);
            tick();
        end
        ms_allow_in = 1'b1;
        #1;
        check("bp_release_allow", 32'(es_allow_in), 32'd1);
        tick();
        check("bp_next_result", es_alu_result, 32'hdead);
        check("bp_next_pc", es_pc, 32'h1c000044);
        ds_to_es_valid = 1'b0;
        tick();

        // Load with addr_ok arriving on the third request cycle
        put(32'h1c000060, 32'h1c000100, 32'h8, OP_ADD, 1'b1, 4'h0, 32'h0, 4'hf, 5'd7);
        tick();
        ds_to_es_valid = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            check("ld_req", 32'(data_sram_req), 32'd1);
            check("ld_addr", data_sram_addr, 32'h1c000108);
            check("ld_wr", 32'(data_sram_wr), 32'd0);
            check("ld_wait_valid", 32'(es_to_ms_valid), 32'd0);
            check("ld_wait_allow", 32'(es_allow_in), 32'd0);
            check("ld_is_load", 32'(es_is_load), 32'd1);
            tick();
        end
        data_sram_addr_ok = 1'b1;
        #1;
        check("ld_ok_req", 32'(data_sram_req), 32'd1);
        check("ld_ok_valid", 32'(es_to_ms_valid), 32'd1);
        check("ld_ok_is_load", 32'(es_is_load), 32'd1);
        check("ld_ok_mem_re", 32'(es_mem_re_o), 32'd1);
        tick();
        data_sram_addr_ok = 1'b0;
        #1;
        check("ld_after_valid", 32'(es_to_ms_valid), 32'd0);
        check("ld_after_req", 32'(data_sram_req), 32'd0);
        check("ld_after_is_load", 32'(es_is_load), 32'd0);

        // Store accepted while MEM stalls: one request pulse, then DONE holds
        put(32'h1c000080, 32'h1c000200, 32'h4, OP_ADD, 1'b0, 4'hf, 32'hdeadbeef, 4'h0, 5'd0);
        tick();
        ds_to_es_valid    = 1'b0;
        ms_allow_in       = 1'b0;
        data_sram_addr_ok = 1'b1;
        #1;
        check("st_req", 32'(data_sram_req), 32'd1);
        check("st_wr", 32'(data_sram_wr), 32'd1);
        check("st_wstrb", 32'(data_sram_wstrb), 32'hf);
        check("st_wdata", data_sram_wdata, 32'hdeadbeef);
        check("st_addr", data_sram_addr, 32'h1c000204);
        check("st_valid", 32'(es_to_ms_valid), 32'd1);
        check("st_allow_in", 32'(es_allow_in), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("st_done_req", 32'(data_sram_req), 32'd0);
            check("st_done_valid", 32'(es_to_ms_valid), 32'd1);
            tick();
        end
        ms_allow_in = 1'b1;
        #1;
        check("st_release_req", 32'(data_sram_req), 32'd0);
        check("st_release_allow", 32'(es_allow_in), 32'd1);
        tick();
        check("st_gone_valid", 32'(es_to_ms_valid), 32'd0);
        check("st_gone_req", 32'(data_sram_req), 32'd0);
        data_sram_addr_ok = 1'b0;

        // Zero strobes and no load: ordinary ALU instruction
        put(32'h1c0000a0, 32'h1, 32'h2, OP_ADD, 1'b0, 4'h0, 32'h0, 4'h0, 5'd0);
        tick();
        ds_to_es_valid = 1'b0;
        #1;
        check("nomem_req", 32'(data_sram_req), 32'd0);
        check("nomem_valid", 32'(es_to_ms_valid), 32'd1);
        tick();

        // Reset during a pending load request
        put(32'h1c0000c0, 32'h1c000300, 32'h0, OP_ADD, 1'b1, 4'h0, 32'h0, 4'hf, 5'd9);
        tick();
        ds_to_es_valid = 1'b0;
        #1;
        check("pend_req", 32'(data_sram_req), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rst_pend_req", 32'(data_sram_req), 32'd0);
        check("rst_pend_valid", 32'(es_to_ms_valid), 32'd0);
        check("rst_pend_rf_we", 32'(es_rf_we), 32'd0);
        check("rst_pend_pc", es_pc, 32'h1c000000);

        // Reset while in DONE must return the FSM to idle
        put(32'h1c0000e0, 32'h1c000400, 32'h0, OP_ADD, 1'b0, 4'h3, 32'h55, 4'h0, 5'd0);
        tick();
        ds_to_es_valid    = 1'b0;
        ms_allow_in       = 1'b0;
        data_sram_addr_ok = 1'b1;
        tick();
        data_sram_addr_ok = 1'b0;
        #1;
        check("done_req", 32'(data_sram_req), 32'd0);
        reset = 1'b1;
        tick();
        reset       = 1'b0;
        ms_allow_in = 1'b1;
        #1;
        check("rst_done_valid", 32'(es_to_ms_valid), 32'd0);
        put(32'h1c000100, 32'h1c000500, 32'h0, OP_ADD, 1'b1, 4'h0, 32'h0, 4'hf, 5'd1);
        tick();
        ds_to_es_valid = 1'b0;
        #1;
        check("rst_done_new_req", 32'(data_sram_req), 32'd1);
        check("rst_done_new_addr", data_sram_addr, 32'h1c000500);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
